// File: rtl/qos_pkg.sv
// Shared types and helpers for the QoS virtual-channel scheduler.
package qos_pkg;

  localparam int unsigned DEFAULT_BW  = 6;
  localparam int unsigned DEFAULT_NVC = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_SERVE = 2'd2,
    ST_PAUSE = 2'd3
  } qos_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/qos_rr_pick.sv
// Round-robin picker: first set request searching upward from last_i+1, wrapping at NVC.
module qos_rr_pick #(
  parameter int unsigned NVC = 4,
  parameter int unsigned VW  = 2
) (
  input  logic [NVC-1:0] req_i,
  input  logic [VW-1:0]  last_i,
  output logic [VW-1:0]  pick_o,
  output logic           any_o
);

  always_comb begin
    logic [VW-1:0] idx;
    pick_o = '0;
    any_o  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NVC; i++) begin
      idx = VW'((32'(last_i) + 32'd1 + i) % NVC);
      if (!any_o && req_i[idx]) begin
        any_o  = 1'b1;
        pick_o = idx;
      end
    end
  end

endmodule

// File: rtl/qos_vc_sched.sv
// Weighted round-robin drain of NVC source FIFOs into one destination FIFO.
module qos_vc_sched
  import qos_pkg::*;
#(
  parameter int unsigned BW  = DEFAULT_BW,
  parameter int unsigned NVC = DEFAULT_NVC,
  parameter int unsigned WW  = 3,
  parameter int unsigned VW  = clog2(DEFAULT_NVC)
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              enable,
  input  logic [NVC-1:0]    vc_empty,
  input  logic [NVC*BW-1:0] vc_data,
  input  logic [NVC*WW-1:0] vc_weight,
  input  logic              dst_almost_full,
  input  logic              dst_full,
  output logic [NVC-1:0]    vc_rd,
  output logic              dst_wr,
  output logic [BW-1:0]     dst_data,
  output logic [VW-1:0]     active_vc,
  output logic [1:0]        state,
  output logic              idle
);

  qos_state_e    state_q, state_d;
  logic [VW-1:0] active_vc_q, active_vc_d;
  logic [VW-1:0] last_vc_q, last_vc_d;
  logic [WW-1:0] credit_q, credit_d;

  logic [VW-1:0] pick;
  logic          any_valid;
  logic [WW-1:0] pick_weight;
  logic          dst_block;
  logic          xfer;

  qos_rr_pick #(
    .NVC (NVC),
    .VW  (VW)
  ) u_pick (
    .req_i  (~vc_empty),
    .last_i (last_vc_q),
    .pick_o (pick),
    .any_o  (any_valid)
  );

  // Zero weight still grants one word so a VC can never be starved by config.
  always_comb begin
    pick_weight = vc_weight[pick*WW +: WW];
    if (pick_weight == '0) pick_weight = WW'(1);
  end

  assign dst_block = dst_full | dst_almost_full;
  assign xfer      = (state_q == ST_SERVE) & enable & ~dst_block & ~vc_empty[active_vc_q];

  assign vc_rd     = xfer ? (NVC'(1) << active_vc_q) : '0;
  assign dst_wr    = xfer;
  assign dst_data  = xfer ? vc_data[active_vc_q*BW +: BW] : '0;
  assign active_vc = active_vc_q;
  assign state     = state_q;
  assign idle      = (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    active_vc_d = active_vc_q;
    last_vc_d   = last_vc_q;
    credit_d    = credit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && (|(~vc_empty))) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!enable || !any_valid) begin
          state_d = ST_IDLE;
        end else begin
          active_vc_d = pick;
          credit_d    = pick_weight;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          last_vc_d = active_vc_q;
          credit_d  = '0;
        end else if (dst_block) begin
          state_d = ST_PAUSE;
        end else if (vc_empty[active_vc_q]) begin
          state_d   = ST_ARB;
          last_vc_d = active_vc_q;
        end else begin
          credit_d = credit_q - WW'(1);
          if (credit_q == WW'(1)) begin
            state_d   = ST_ARB;
            last_vc_d = active_vc_q;
          end
        end
      end
      ST_PAUSE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (!dst_block) begin
          state_d = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_IDLE;
      active_vc_q <= '0;
      last_vc_q   <= VW'(NVC - 1);
      credit_q    <= '0;
    end else begin
      state_q     <= state_d;
      active_vc_q <= active_vc_d;
      last_vc_q   <= last_vc_d;
      credit_q    <= credit_d;
    end
  end

endmodule

// File: tb/tb_qos_vc_sched.sv
// Directed bench for qos_vc_sched with a small source-FIFO model and per-cycle expectations.
module tb_qos_vc_sched;

  localparam int unsigned BW  = 6;
  localparam int unsigned NVC = 4;
  localparam int unsigned WW  = 3;
  localparam int unsigned VW  = 2;

  logic              clk;
  logic              reset_L;
  logic              enable;
  logic [NVC-1:0]    vc_empty;
  logic [NVC*BW-1:0] vc_data;
  logic [NVC*WW-1:0] vc_weight;
  logic              dst_almost_full;
  logic              dst_full;
  logic [NVC-1:0]    vc_rd;
  logic              dst_wr;
  logic [BW-1:0]     dst_data;
  logic [VW-1:0]     active_vc;
  logic [1:0]        state;
  logic              idle;

  int          n_checks;
  int          n_fail;
  int          sc[NVC];
  logic [3:0]  sq[NVC];

  qos_vc_sched #(
    .BW  (BW),
    .NVC (NVC),
    .WW  (WW),
    .VW  (VW)
  ) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .enable          (enable),
    .vc_empty        (vc_empty),
    .vc_data         (vc_data),
    .vc_weight       (vc_weight),
    .dst_almost_full (dst_almost_full),
    .dst_full        (dst_full),
    .vc_rd           (vc_rd),
    .dst_wr          (dst_wr),
    .dst_data        (dst_data),
    .active_vc       (active_vc),
    .state           (state),
    .idle            (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Source word = {vc, seq}; empty when the remaining count is zero.
  task automatic refresh_src();
    for (int i = 0; i < NVC; i++) begin
      vc_empty[i] = (sc[i] == 0);
      vc_data[i*BW +: BW] = {2'(i), sq[i]};
    end
  endtask

  task automatic load(input int vc, input int n);
    sc[vc] = n;
    sq[vc] = 4'd0;
    refresh_src();
  endtask

  task automatic clear_src();
    for (int i = 0; i < NVC; i++) begin
      sc[i] = 0;
      sq[i] = 4'd0;
    end
    refresh_src();
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, then pop any source that was read.
  // dat < 0 means no transfer is expected this cycle.
  task automatic step(input bit en, input bit af, input bit ff, input int st, input int dat);
    logic [NVC-1:0] rd_seen;
    enable          = en;
    dst_almost_full = af;
    dst_full        = ff;
    @(negedge clk);
    check("state", 32'(state), 32'(st));
    check("idle", 32'(idle), 32'(st == 0));
    check("dst_wr", 32'(dst_wr), 32'(dat >= 0));
    if (dat >= 0) begin
      check("dst_data", 32'(dst_data), 32'(dat));
      check("vc_rd", 32'(vc_rd), 32'(1) << (dat / 16));
      check("active_vc", 32'(active_vc), 32'(dat / 16));
    end else begin
      check("vc_rd_idle", 32'(vc_rd), 32'd0);
      check("dst_data_idle", 32'(dst_data), 32'd0);
    end
    rd_seen = vc_rd;
    @(posedge clk);
    #1;
    for (int i = 0; i < NVC; i++) begin
      if (rd_seen[i] && sc[i] > 0) begin
        sc[i]--;
        sq[i] = sq[i] + 4'd1;
      end
    end
    refresh_src();
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset_L         = 1'b0;
    enable          = 1'b0;
    dst_almost_full = 1'b0;
    dst_full        = 1'b0;
    vc_weight       = '0;
    vc_data         = '0;
    vc_empty        = '1;
    clear_src();
    #2;
    check("rst_state", 32'(state), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_vc_rd", 32'(vc_rd), 32'd0);
    check("rst_dst_wr", 32'(dst_wr), 32'd0);
    check("rst_dst_data", 32'(dst_data), 32'd0);
    check("rst_active_vc", 32'(active_vc), 32'd0);
    @(posedge clk);
    #1;
    reset_L = 1'b1;

    // Weighted RR {1,2,3,1}, all VCs full
    vc_weight = {3'd1, 3'd3, 3'd2, 3'd1};
    for (int i = 0; i < NVC; i++) load(i, 10);
    step(1, 0, 0, 0, -1);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 0);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 16);
    step(1, 0, 0, 2, 17);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 32);
    step(1, 0, 0, 2, 33);
    step(1, 0, 0, 2, 34);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 48);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 1);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 18);

    // Asynchronous reset in the middle of VC1's grant
    reset_L = 1'b0;
    #1;
    check("midrst_vc_rd", 32'(vc_rd), 32'd0);
    check("midrst_dst_wr", 32'(dst_wr), 32'd0);
    check("midrst_state", 32'(state), 32'd0);
    clear_src();
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    step(1, 0, 0, 0, -1);
    step(1, 0, 0, 0, -1);
    step(1, 0, 0, 0, -1);

    // Empty skip: only VC2 with 2 words, weight 4
    vc_weight = {3'd1, 3'd4, 3'd2, 3'd1};
    load(2, 2);
    step(1, 0, 0, 0, -1);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 32);
    step(1, 0, 0, 2, 33);
    step(1, 0, 0, 2, -1);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 0, -1);

    // Throttle: VC0 weight 3, almost-full after first word, then full alone
    vc_weight = {3'd1, 3'd4, 3'd2, 3'd3};
    clear_src();
    load(0, 3);
    step(1, 0, 0, 0, -1);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 0);
    step(1, 1, 0, 2, -1);
    step(1, 0, 1, 3, -1);
    step(1, 0, 0, 3, -1);
    step(1, 0, 0, 2, 1);
    step(1, 0, 0, 2, 2);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 0, -1);

    // Weight 0 on VC1 behaves as 1
    vc_weight = {3'd1, 3'd4, 3'd0, 3'd3};
    clear_src();
    load(1, 3);
    step(1, 0, 0, 0, -1);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 16);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 17);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 18);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 0, -1);

    // Enable drop during VC2's grant; next grant goes to VC3
    vc_weight = {3'd2, 3'd2, 3'd2, 3'd2};
    clear_src();
    for (int i = 0; i < NVC; i++) load(i, 4);
    step(1, 0, 0, 0, -1);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 32);
    step(0, 0, 0, 2, -1);
    step(0, 0, 0, 0, -1);
    step(1, 0, 0, 0, -1);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 48);
    step(1, 0, 0, 2, 49);
    step(1, 0, 0, 1, -1);
    step(1, 0, 0, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
